// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch stage of the P7 pipeline. Owns the program counter,
//               drives the instruction-memory address, applies exception,
//               eret and branch/jump redirects, and flags fetch address
//               errors (AdEL) towards the F/D pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] PC_INIT   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX    = 32'h0000_6FFC,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        d_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD
);

  localparam logic [31:0] c_WORD = 32'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        w_eret;
  logic [31:0] w_fa;
  logic        w_fault;

  // While reset is held the stage must present the reset PC regardless of
  // what the register or the D stage currently hold, so eret is masked.
  assign w_eret = eret & ~reset;

  // Fetch address: eret has no delay slot, so EPC is fetched immediately.
  always_comb begin
    w_fa = pc_q;
    if (reset) begin
      w_fa = PC_INIT;
    end else if (w_eret) begin
      w_fa = epc;
    end
  end

  // Illegal fetch: misaligned or outside instruction memory (unsigned compare).
  always_comb begin
    w_fault = (w_fa[1:0] != 2'b00) || (w_fa < PC_INIT) || (w_fa > PC_MAX);
  end

  assign i_inst_addr = w_fa;
  assign F_PC        = w_fa;
  assign F_BD        = d_is_jump & ~w_eret;

  // Faulting fetches become a nop carrying AdEL; the trap arrives later via req.
  always_comb begin
    F_Instr   = i_inst_rdata;
    F_ExcCode = 5'd0;
    if (w_fault) begin
      F_Instr   = 32'd0;
      F_ExcCode = EXC_ADEL;
    end
  end

  // Next-PC priority: exception request beats everything and ignores stall;
  // eret beats branch/jump; redirects issued during a stall are not latched.
  always_comb begin
    pc_d = pc_q;
    if (req) begin
      pc_d = EXC_ENTRY;
    end else if (en && eret) begin
      pc_d = epc + c_WORD;
    end else if (en && redirect) begin
      pc_d = redirect_pc;
    end else if (en) begin
      pc_d = pc_q + c_WORD;
    end
  end

  // Program counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_INIT;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. Each stimulus cycle
//               pushes the expected F-stage outputs into a scoreboard queue,
//               which is popped and compared mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_is_jump;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic [4:0]  F_ExcCode;
  logic        F_BD;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  exp_t r_sb[$];
  int   r_checks = 0;
  int   r_errors = 0;

  fetch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .d_is_jump    (d_is_jump),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_PC         (F_PC),
    .F_Instr      (F_Instr),
    .F_ExcCode    (F_ExcCode),
    .F_BD         (F_BD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  // One clock of stimulus: exp_pc is the address the F stage must present in
  // this cycle; everything else is derived from it and the drive values.
  task automatic step(input logic rst, input logic e, input logic rq, input logic er,
                      input logic [31:0] ep, input logic rd, input logic [31:0] rpc,
                      input logic dj, input logic [31:0] exp_pc);
    exp_t x;
    exp_t o;
    @(posedge clk);
    #1;
    reset        = rst;
    en           = e;
    req          = rq;
    eret         = er;
    epc          = ep;
    redirect     = rd;
    redirect_pc  = rpc;
    d_is_jump    = dj;
    i_inst_rdata = $urandom;
    x.pc    = exp_pc;
    x.instr = is_fault(exp_pc) ? 32'd0 : i_inst_rdata;
    x.exc   = is_fault(exp_pc) ? 5'd4 : 5'd0;
    x.bd    = rst ? dj : (dj & ~er);
    r_sb.push_back(x);
    @(negedge clk);
    if (r_sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      o = r_sb.pop_front();
      chk("F_PC", F_PC, o.pc);
      chk("i_inst_addr", i_inst_addr, o.pc);
      chk("F_Instr", F_Instr, o.instr);
      chk("F_ExcCode", {27'd0, F_ExcCode}, {27'd0, o.exc});
      chk("F_BD", {31'd0, F_BD}, {31'd0, o.bd});
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; req = 1'b0; eret = 1'b0; epc = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; d_is_jump = 1'b0; i_inst_rdata = 32'd0;

    // Reset held two cycles; eret and jump asserted to check masking.
    step(1, 0, 0, 1, 32'h5000, 0, 0, 1, 32'h3000);
    step(1, 0, 0, 1, 32'h5000, 0, 0, 1, 32'h3000);
    // Sequential fetch after release.
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3000);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3004);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3008);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h300C);
    // Stall holds the PC.
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h3010);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h3010);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h3010);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3010);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3014);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3018);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h301C);
    // Branch at 3020 with delay slot flag.
    step(0, 1, 0, 0, 0, 1, 32'h3400, 1, 32'h3020);
    step(0, 1, 0, 0, 0, 1, 32'h3050, 1, 32'h3400);
    // Exception request during stall, then req beating redirect.
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h3050);
    step(0, 1, 1, 0, 0, 1, 32'h3000, 0, 32'h4180);
    // Illegal targets: misaligned, above, below; then the top legal word.
    step(0, 1, 0, 0, 0, 1, 32'h3002, 0, 32'h4180);
    step(0, 1, 0, 0, 0, 1, 32'h7000, 0, 32'h3002);
    step(0, 1, 0, 0, 0, 1, 32'h2FFC, 0, 32'h7000);
    step(0, 1, 0, 0, 0, 1, 32'h6FFC, 0, 32'h2FFC);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h6FFC);
    step(0, 1, 0, 0, 0, 1, 32'h4200, 0, 32'h7000);
    // eret during stall, then eret beating redirect.
    step(0, 0, 0, 1, 32'h3120, 0, 0, 1, 32'h3120);
    step(0, 1, 0, 1, 32'h3120, 1, 32'h3400, 1, 32'h3120);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3124);
    // Wrap-around at the top of the address space.
    step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h3128);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
    // Redirect while stalled is not latched.
    step(0, 0, 0, 0, 0, 1, 32'h3300, 0, 32'h0000_0004);
    // Reset mid-stall with a pending redirect.
    step(1, 0, 0, 0, 0, 1, 32'h3300, 0, 32'h3000);
    // req beats eret; fetch still shows the EPC this cycle.
    step(0, 1, 1, 1, 32'h3500, 0, 0, 1, 32'h3500);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h4180);
    // Misaligned EPC faults, and the PC keeps advancing from it.
    step(0, 1, 0, 1, 32'h3121, 0, 0, 0, 32'h3121);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h3125);

    if (r_sb.size() != 0) begin
      chk("scoreboard_residue", r_sb.size(), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule
`default_nettype wire
